// File: rtl/grf_scoreboard_if.sv
// Bundle of read, issue, writeback and kill signals between the decode stage and the
// general register file scoreboard. Port i of a flattened vector occupies [i*W +: W].
interface grf_scoreboard_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2
);
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS-1:0]        rd_need;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_pend;
  logic                       stall;
  logic                       issue_valid;
  logic                       issue_we;
  logic [ADDR_W-1:0]          issue_addr;
  logic                       issue_ready;
  logic                       wb_we;
  logic [ADDR_W-1:0]          wb_addr;
  logic [DATA_W-1:0]          wb_data;
  logic                       kill_valid;
  logic [ADDR_W-1:0]          kill_addr;
  logic                       sb_err;

  modport master (
    output rd_addr, rd_need, issue_valid, issue_we, issue_addr,
           wb_we, wb_addr, wb_data, kill_valid, kill_addr,
    input  rd_data, rd_pend, stall, issue_ready, sb_err
  );

  modport slave (
    input  rd_addr, rd_need, issue_valid, issue_we, issue_addr,
           wb_we, wb_addr, wb_data, kill_valid, kill_addr,
    output rd_data, rd_pend, stall, issue_ready, sb_err
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Decode-stage register file with per-register pending-write counters and operand stall.
// Define GRF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module grf_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RD_PORTS = 2,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  grf_scoreboard_if.slave  bus
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs     [NREG];
  logic [CNT_W-1:0]  cnt      [NREG];
  logic [CNT_W-1:0]  cnt_next [NREG];
  logic [NREG-1:0]   under;
  logic              sb_err_q;

  logic issue_acc;
  logic wb_en;
  logic kill_en;

  // Register 0 is hard-wired: every event aimed at it is dropped here.
  assign bus.issue_ready = (cnt[bus.issue_addr] != CNT_MAX) || (bus.issue_addr == '0);
  assign issue_acc = bus.issue_valid && bus.issue_we && bus.issue_ready
                     && (bus.issue_addr != '0);
  assign wb_en     = bus.wb_we && (bus.wb_addr != '0);
  assign kill_en   = bus.kill_valid && (bus.kill_addr != '0);
  assign bus.sb_err = sb_err_q;

  // Returns {underflow, new_count}; a decrement below zero clamps the count at zero.
  function automatic logic [CNT_W:0] cnt_update(
    input logic [CNT_W-1:0] c,
    input logic             inc,
    input logic             dec_wb,
    input logic             dec_kill
  );
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] dec;
    sum = {2'b00, c} + {{(CNT_W+1){1'b0}}, inc};
    dec = {{(CNT_W+1){1'b0}}, dec_wb} + {{(CNT_W+1){1'b0}}, dec_kill};
    if (sum < dec) return {1'b1, {CNT_W{1'b0}}};
    return {1'b0, CNT_W'(sum - dec)};
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    under = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_next[r] = cnt[r];
      {under[r], cnt_next[r]} = cnt_update(
        cnt[r],
        issue_acc && (bus.issue_addr == ADDR_W'(r)),
        wb_en     && (bus.wb_addr    == ADDR_W'(r)),
        kill_en   && (bus.kill_addr  == ADDR_W'(r)));
    end
  end

  // NOTE: the register array is reset too, because all registers must read zero straight out of reset.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      if (wb_en) regs[bus.wb_addr] <= bus.wb_data;
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_next[r];
      if (|under) sb_err_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef GRF_BYPASS_EN
    logic wb_hit;
    assign wb_hit = wb_en && (bus.wb_addr == a);
    assign bus.rd_data[i*DATA_W +: DATA_W] = wb_hit ? bus.wb_data : regs[a];
    // A single outstanding write that lands this cycle is satisfied by the bypass.
    assign bus.rd_pend[i] = (a != '0) &&
                            ((cnt[a] > CNT_W'(1)) || ((cnt[a] == CNT_W'(1)) && !wb_hit));
`else
    assign bus.rd_data[i*DATA_W +: DATA_W] = regs[a];
    assign bus.rd_pend[i] = (a != '0) && (cnt[a] != '0);
`endif
  end

  assign bus.stall = |(bus.rd_need & bus.rd_pend);

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: expectations are queued with each cycle's
// stimulus and compared against the DUT outputs on the falling clock edge.
module tb_grf_scoreboard;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int RD_PORTS = 2;
  localparam int CNT_W    = 2;

  typedef enum logic [2:0] {K_DATA0, K_DATA1, K_PEND0, K_PEND1, K_STALL, K_READY, K_ERR} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  grf_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS)) bus ();

  grf_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_DATA0: return bus.rd_data[31:0];
      K_DATA1: return bus.rd_data[63:32];
      K_PEND0: return {31'd0, bus.rd_pend[0]};
      K_PEND1: return {31'd0, bus.rd_pend[1]};
      K_STALL: return {31'd0, bus.stall};
      K_READY: return {31'd0, bus.issue_ready};
      default: return {31'd0, bus.sb_err};
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_e k, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.kind = k; x.exp = e;
    exp_q.push_back(x);
  endtask

  task automatic settle_now();
    exp_t x;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check(x.tag, observe(x.kind), x.exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    settle_now();
  endtask

  task automatic idle();
    bus.rd_addr     = '0;
    bus.rd_need     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_addr  = '0;
    bus.wb_we       = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.kill_valid  = 1'b0;
    bus.kill_addr   = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int port, input logic [4:0] a, input logic need);
    bus.rd_addr[port*ADDR_W +: ADDR_W] = a;
    bus.rd_need[port] = need;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_addr  = a;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  task automatic kill(input logic [4:0] a);
    bus.kill_valid = 1'b1;
    bus.kill_addr  = a;
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // Outputs while held in reset
    rd(0, 5'd3, 1'b1); rd(1, 5'd7, 1'b1);
    expect_val("rst_stall", K_STALL, 0);
    expect_val("rst_ready", K_READY, 1);
    expect_val("rst_pend0", K_PEND0, 0);
    expect_val("rst_err",   K_ERR,   0);
    expect_val("rst_data0", K_DATA0, 0);
    settle();
    next();
    next();
    reset = 1'b1;

    // Every register reads zero after reset
    for (int r = 0; r < 32; r++) begin
      rd(0, 5'(r), 1'b1); rd(1, 5'(31 - r), 1'b1);
      expect_val("init_data0", K_DATA0, 0);
      expect_val("init_data1", K_DATA1, 0);
      expect_val("init_stall", K_STALL, 0);
      settle();
      next();
    end
    expect_val("init_err", K_ERR, 0);
    settle();
    next();

    // Same-cycle bypass on r5
    issue(5'd5);
    expect_val("byp_issue_ready", K_READY, 1);
    settle(); next();
    rd(0, 5'd5, 1'b1);
    expect_val("byp_pend_before", K_PEND0, 1);
    expect_val("byp_stall_before", K_STALL, 1);
    settle(); next();
    rd(0, 5'd5, 1'b1); wb(5'd5, 32'hDEAD_BEEF);
`ifdef GRF_BYPASS_EN
    expect_val("byp_wb_data", K_DATA0, 32'hDEAD_BEEF);
    expect_val("byp_wb_stall", K_STALL, 0);
`else
    expect_val("byp_wb_data", K_DATA0, 0);
    expect_val("byp_wb_stall", K_STALL, 1);
`endif
    settle(); next();
    rd(0, 5'd5, 1'b1);
    expect_val("byp_after_data", K_DATA0, 32'hDEAD_BEEF);
    expect_val("byp_after_stall", K_STALL, 0);
    settle(); next();

    // Three writes in flight to r7; the fourth issue is refused
    for (int k = 0; k < 3; k++) begin
      issue(5'd7);
      expect_val("multi_ready", K_READY, 1);
      settle(); next();
    end
    issue(5'd7); rd(1, 5'd7, 1'b1);
    expect_val("multi_full_ready", K_READY, 0);
    expect_val("multi_full_pend1", K_PEND1, 1);
    settle(); next();
    for (int k = 0; k < 3; k++) begin
      rd(1, 5'd7, 1'b1); wb(5'd7, 32'h70 + 32'(k + 1));
`ifdef GRF_BYPASS_EN
      expect_val("multi_wb_stall", K_STALL, (k == 2) ? 0 : 1);
`else
      expect_val("multi_wb_stall", K_STALL, 1);
`endif
      settle(); next();
    end
    rd(1, 5'd7, 1'b1); bus.issue_addr = 5'd7;
    expect_val("multi_done_stall", K_STALL, 0);
    expect_val("multi_done_data1", K_DATA1, 32'h73);
    expect_val("multi_done_ready", K_READY, 1);
    expect_val("multi_done_err",   K_ERR,   0);
    settle(); next();

    // Issue, writeback and kill hitting r9 in one cycle
    issue(5'd9);
    settle(); next();
    issue(5'd9); wb(5'd9, 32'h99); kill(5'd9); rd(0, 5'd9, 1'b1);
    expect_val("simul_ready", K_READY, 1);
`ifdef GRF_BYPASS_EN
    expect_val("simul_pend_same", K_PEND0, 0);
`else
    expect_val("simul_pend_same", K_PEND0, 1);
`endif
    settle(); next();
    rd(0, 5'd9, 1'b1);
    expect_val("simul_pend_after", K_PEND0, 0);
    expect_val("simul_data", K_DATA0, 32'h99);
    expect_val("simul_err", K_ERR, 0);
    settle(); next();

    // Events aimed at r0 change nothing
    issue(5'd0); wb(5'd0, 32'hFFFF_FFFF); kill(5'd0); rd(0, 5'd0, 1'b1);
    expect_val("r0_ready", K_READY, 1);
    expect_val("r0_data_same", K_DATA0, 0);
    expect_val("r0_stall_same", K_STALL, 0);
    settle(); next();
    rd(0, 5'd0, 1'b1); rd(1, 5'd0, 1'b1);
    expect_val("r0_data_after", K_DATA0, 0);
    expect_val("r0_pend_after", K_PEND1, 0);
    expect_val("r0_err", K_ERR, 0);
    settle(); next();

    // Writeback underflow on r3
    wb(5'd3, 32'h12);
    expect_val("uf_err_before", K_ERR, 0);
    settle(); next();
    rd(0, 5'd3, 1'b1);
    expect_val("uf_err_set", K_ERR, 1);
    expect_val("uf_data", K_DATA0, 32'h12);
    expect_val("uf_pend", K_PEND0, 0);
    settle(); next();
    expect_val("uf_err_sticky", K_ERR, 1);
    settle(); next();

    // Asynchronous reset with two writes pending on r4
    wb(5'd4, 32'h44);
    settle(); next();
    issue(5'd4);
    settle(); next();
    issue(5'd4);
    settle(); next();
    rd(0, 5'd4, 1'b1);
    expect_val("ar_stall_before", K_STALL, 1);
    expect_val("ar_data_before", K_DATA0, 32'h44);
    settle();
    #2 reset = 1'b0;
    #1;
    expect_val("ar_stall_during", K_STALL, 0);
    expect_val("ar_pend_during", K_PEND0, 0);
    expect_val("ar_data_during", K_DATA0, 0);
    expect_val("ar_err_during", K_ERR, 0);
    settle_now();
    next();
    reset = 1'b1;
    wb(5'd4, 32'h55);
    expect_val("ar_err_clear", K_ERR, 0);
    settle(); next();
    rd(0, 5'd4, 1'b1);
    expect_val("ar_late_wb_err", K_ERR, 1);
    expect_val("ar_late_wb_data", K_DATA0, 32'h55);
    settle(); next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Parametrised successor to the decode-stage register file: a 2^ADDR_W-entry general register file with RD_PORTS read ports, a per-register pending-write scoreboard and write-through bypass. It sits in the ID stage. It produces operands and a decode stall for instructions whose sources are still in flight. It tracks every issued destination until it is written back or killed.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width; register count is 2^ADDR_W
- RD_PORTS, 2, number of read ports (1..4)
- CNT_W, 2, pending counter width; at most 2^CNT_W-1 writes in flight per register

Ports (flattened vectors; port i occupies slice [i*W +: W]):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  RD_PORTS*ADDR_W  read addresses
- rd_need  in  RD_PORTS  port i's operand is consumed by the instruction in ID
- rd_data  out  RD_PORTS*DATA_W  read data, bypassed
- rd_pend  out  RD_PORTS  register is pending and not satisfied by this cycle's writeback
- stall  out  1  OR over i of (rd_need[i] & rd_pend[i])
- issue_valid  in  1  the instruction leaves ID this cycle
- issue_we  in  1  the issued instruction writes a register
- issue_addr  in  ADDR_W  destination of the issued instruction
- issue_ready  out  1  low when the issue_addr counter is saturated
- wb_we  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- kill_valid  in  1  a previously issued write was squashed
- kill_addr  in  ADDR_W  destination of the squashed write
- sb_err  out  1  sticky underflow error

## Operation
- Register 0 reads as 0, is never written, and is never pending. Issue, writeback or kill to address 0 is ignored and does not assert sb_err.
- The scoreboard holds a per-register counter cnt[r] of CNT_W bits.
- Issue accepted when issue_valid & issue_we & issue_ready & issue_addr≠0; an accepted issue increments cnt[issue_addr].
- Decrement events: a writeback (wb_we, wb_addr≠0) decrements cnt[wb_addr]; a kill decrements cnt[kill_addr].
- Net update per register per cycle = +issue − wb − kill; all three can hit the same address in one cycle.
- Underflow: if a decrement would take cnt below 0, cnt stays 0 and sb_err sets. sb_err is cleared only by reset.
- issue_ready = (cnt[issue_addr] ≠ 2^CNT_W−1) | (issue_addr = 0). Issue while not ready is ignored, with no counter change.
- Read: rd_data[i] = wb_data if (wb_we & wb_addr = rd_addr[i] ≠ 0), else array[rd_addr[i]].
- rd_pend[i] = (cnt[a] > 1) | (cnt[a] = 1 & !(wb_we & wb_addr = a)), where a = rd_addr[i] ≠ 0.
- A kill in the same cycle does not clear rd_pend.
- Writeback with cnt = 0 still writes the array; only the counter update and sb_err follow the underflow rule.

## Timing
- The read path, rd_pend, stall and issue_ready are combinational from inputs and state, with zero latency.
- The array and counters update on the rising edge of clk.
- A write at edge N is visible through the array from edge N onward. With bypass, the written value is also readable in cycle N−1, the cycle wb_we is high.
- Reset (reset low) takes effect immediately, with no clock needed. All registers read 0, all cnt = 0, and sb_err = 0.
- Output values during reset: stall = 0, rd_pend = 0, issue_ready = 1, and rd_data = 0 unless a bypass hit is presented.
- Reset mid-flight discards all pending state. Later writebacks to those registers assert sb_err.

## Configuration
- GRF_BYPASS_EN defined: write-through bypass as above; a count-1 register being written this cycle is not pending.
- Undefined: rd_data always comes from the array. rd_pend[i] = cnt[a] > 0, so a stalled consumer waits one extra cycle past writeback. The counter logic is unchanged.

## Test plan
- Reset and read: assert reset low, then release. Read r0..r31 on all ports → every rd_data = 0, stall = 0, sb_err = 0.
- Same-cycle bypass: issue r5, then two cycles later wb r5 = 0xDEADBEEF with port0 reading r5 and rd_need[0] = 1. With GRF_BYPASS_EN: rd_data[0] = 0xDEADBEEF, stall = 0. Without: stall = 1 that cycle, data visible next cycle.
- Multiple in flight: issue r7 three times, so cnt = 3 and issue_ready = 0. A fourth issue is ignored. Then wb r7 three times. stall stays 1 until the third writeback cycle (bypass on).
- Simultaneous events: cnt[r9] = 1; in one cycle apply issue r9 + wb r9 + kill r9 → cnt[r9] = 0 after the edge, no sb_err.
- Underflow: wb r3 = 0x12 with cnt[r3] = 0 → sb_err = 1 and sticky, r3 reads 0x12. Writes, issues and kills to r0 never change state.
- Asynchronous reset mid-flight: pull reset low between clock edges with cnt[r4] = 2 → stall drops immediately and r4 reads 0.
